// File: rtl/life_monitor.sv
// -----------------------------------------------------------------------------
// life_monitor
//
// Downstream monitor for the 16x16 Game of Life generator. Each accepted
// generation is snapshotted, its live cells are counted one row per cycle,
// and it is compared with the previous generation(s). The result flags
// extinction, still life and period-2 oscillation, and a sticky halt is
// raised so the top level can stop stepping the generator.
//
// Optional feature macro: LIFE_MON_OSC2_EN
//   defined     : two-back history (prev2/hv2) is built and osc2 is live.
//   not defined : prev2/hv2 are omitted, osc2 is tied 0 and
//                 halt = extinct | still. Timing is identical.
//
// Parameters
//   N      grid side; the grid is N*N bits, row r = bits [N*r+N-1 : N*r]
//   GEN_W  generation counter width
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (highest priority)
//   clear       synchronous clear of history, counters and flags
//   grid_in     current generation (N*N bits)
//   grid_valid  single-cycle strobe; only accepted while idle
//   busy        high while a grid is being scanned/compared
//   done        one-cycle pulse when the status outputs have been updated
//   population  live-cell count of the last accepted grid
//   gen_count   accepted generations since reset/clear, saturating
//   extinct     last grid was all zero
//   still       last grid equals the one before it
//   osc2        last grid equals the one two back and differs from the last
//   halt        sticky OR of extinct/still/osc2
//   overrun     sticky; grid_valid arrived while busy
// -----------------------------------------------------------------------------
module life_monitor #(
    parameter int N     = 16,
    parameter int GEN_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [N*N-1:0]              grid_in,
    input  logic                        grid_valid,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(N*N+1)-1:0]    population,
    output logic [GEN_W-1:0]            gen_count,
    output logic                        extinct,
    output logic                        still,
    output logic                        osc2,
    output logic                        halt,
    output logic                        overrun
);

    localparam int CELLS = N * N;
    localparam int PW    = $clog2(CELLS + 1);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CMP  = 2'd2
    } state_t;

    // Number of set bits in one grid row, widened to the accumulator width.
    function automatic logic [PW-1:0] row_popcount(input logic [N-1:0] bits);
        logic [PW-1:0] cnt;
        cnt = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt = cnt + PW'(bits[i]);
        end
        return cnt;
    endfunction

    state_t              state_r;
    logic [CELLS-1:0]    snap_r;
    logic [CELLS-1:0]    prev1_r;
    logic                hv1_r;
    logic [PW-1:0]       acc_r;
    logic [ROW_W-1:0]    row_r;

    logic                busy_r;
    logic                done_r;
    logic [PW-1:0]       population_r;
    logic [GEN_W-1:0]    gen_count_r;
    logic                extinct_r;
    logic                still_r;
    logic                halt_r;
    logic                overrun_r;

    logic [N-1:0]        row_bits_s;
    logic [PW-1:0]       acc_next_s;
    logic                extinct_s;
    logic                still_s;
    logic                osc2_s;

`ifdef LIFE_MON_OSC2_EN
    logic [CELLS-1:0]    prev2_r;
    logic                hv2_r;
    logic                osc2_r;

    // Period-2: matches two back but not the immediately previous grid.
    assign osc2_s = hv2_r & (snap_r == prev2_r) & (snap_r != prev1_r);
    assign osc2   = osc2_r;
`else
    assign osc2_s = 1'b0;
    assign osc2   = 1'b0;
`endif

    // Row currently being counted and the running total including it.
    assign row_bits_s = snap_r[row_r*N +: N];
    assign acc_next_s = acc_r + row_popcount(row_bits_s);

    // Comparison terms evaluated in CMP; acc_r is complete by then.
    assign extinct_s = (acc_r == {PW{1'b0}});
    assign still_s   = hv1_r & (snap_r == prev1_r);

    // Control FSM, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r      <= IDLE;
            snap_r       <= {CELLS{1'b0}};
            prev1_r      <= {CELLS{1'b0}};
            hv1_r        <= 1'b0;
            acc_r        <= {PW{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            population_r <= {PW{1'b0}};
            gen_count_r  <= {GEN_W{1'b0}};
            extinct_r    <= 1'b0;
            still_r      <= 1'b0;
            halt_r       <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef LIFE_MON_OSC2_EN
            prev2_r      <= {CELLS{1'b0}};
            hv2_r        <= 1'b0;
            osc2_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grid_valid) begin
                        snap_r  <= grid_in;
                        acc_r   <= {PW{1'b0}};
                        row_r   <= {ROW_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= SCAN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    acc_r <= acc_next_s;
                    row_r <= row_r + ROW_W'(1);
                    if (row_r == ROW_W'(N - 1)) begin
                        state_r <= CMP;
                    end else begin
                        state_r <= SCAN;
                    end
                    // A strobe while busy is dropped; only the flag records it.
                    if (grid_valid) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= overrun_r;
                    end
                end
                CMP: begin
                    population_r <= acc_r;
                    extinct_r    <= extinct_s;
                    still_r      <= still_s;
                    halt_r       <= halt_r | extinct_s | still_s | osc2_s;
                    prev1_r      <= snap_r;
                    hv1_r        <= 1'b1;
`ifdef LIFE_MON_OSC2_EN
                    osc2_r       <= osc2_s;
                    prev2_r      <= prev1_r;
                    hv2_r        <= hv1_r;
`endif
                    if (gen_count_r != {GEN_W{1'b1}}) begin
                        gen_count_r <= gen_count_r + GEN_W'(1);
                    end else begin
                        gen_count_r <= gen_count_r;
                    end
                    if (grid_valid) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= overrun_r;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign population = population_r;
    assign gen_count  = gen_count_r;
    assign extinct    = extinct_r;
    assign still      = still_r;
    assign halt       = halt_r;
    assign overrun    = overrun_r;

endmodule
